// File: rtl/half_subtractor_core_if.sv
// Input/result bundle for half_subtractor_core: valid-qualified operands in, registered results out.
interface half_subtractor_core_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bout;

    modport master (output in_valid, a, b, input out_valid, diff, bout);
    modport slave  (input in_valid, a, b, output out_valid, diff, bout);
endinterface

// File: rtl/half_subtractor_core.sv
// Registered lane-replicated half subtractor (diff = a^b, bout = ~a&b), one cycle latency.
// Define HALF_SUB_BORROW_COUNT_EN to add the saturating borrow-event counter (cnt_clr/borrow_cnt).
module half_subtractor_core #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    half_subtractor_core_if.slave bus
`ifdef HALF_SUB_BORROW_COUNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      borrow_cnt
`endif
);

    if (WIDTH == 0 || CNT_W == 0) begin : g_param_chk
        $error("half_subtractor_core: WIDTH and CNT_W must be non-zero");
    end

    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] bout_c;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] bout_q;
    logic             out_valid_q;

    // Per-lane arithmetic; lanes never exchange borrows.
    always_comb begin
        diff_c = bus.a ^ bus.b;
        bout_c = ~bus.a & bus.b;
    end

    // Result registers hold their value while no valid input arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q      <= '0;
            bout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                diff_q <= diff_c;
                bout_q <= bout_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

`ifdef HALF_SUB_BORROW_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_evt_c;

    assign borrow_evt_c = bus.in_valid && (|bout_c);

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (borrow_evt_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_subtractor_core.sv
// Directed self-checking bench for half_subtractor_core (WIDTH=1 and WIDTH=4 instances).
module tb_half_subtractor_core;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    half_subtractor_core_if #(.WIDTH(1)) bus1 ();
    half_subtractor_core_if #(.WIDTH(4)) bus4 ();

`ifdef HALF_SUB_BORROW_COUNT_EN
    logic       cnt_clr1;
    logic [1:0] borrow_cnt1;
    logic       cnt_clr4;
    logic [1:0] borrow_cnt4;
`endif

    half_subtractor_core #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus1.slave)
`ifdef HALF_SUB_BORROW_COUNT_EN
        ,
        .cnt_clr    (cnt_clr1),
        .borrow_cnt (borrow_cnt1)
`endif
    );

    half_subtractor_core #(.WIDTH(4), .CNT_W(2)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus4.slave)
`ifdef HALF_SUB_BORROW_COUNT_EN
        ,
        .cnt_clr    (cnt_clr4),
        .borrow_cnt (borrow_cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] tt_in [4];
        logic [1:0] tt_out [4];
        checks = 0;
        errors = 0;
        tt_in[0] = 2'b00; tt_out[0] = 2'b00;
        tt_in[1] = 2'b10; tt_out[1] = 2'b10;
        tt_in[2] = 2'b01; tt_out[2] = 2'b11;
        tt_in[3] = 2'b11; tt_out[3] = 2'b00;

        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0;
`ifdef HALF_SUB_BORROW_COUNT_EN
        cnt_clr1 = 1'b0;
        cnt_clr4 = 1'b0;
`endif
        #3;
        chk("reset_diff", 32'(bus1.diff), 32'h0);
        chk("reset_bout", 32'(bus1.bout), 32'h0);
        chk("reset_out_valid", 32'(bus1.out_valid), 32'h0);
        chk("reset_diff4", 32'(bus4.diff), 32'h0);
`ifdef HALF_SUB_BORROW_COUNT_EN
        chk("reset_cnt", 32'(borrow_cnt1), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table, one vector per cycle
        for (int i = 0; i < 4; i++) begin
            bus1.in_valid = 1'b1;
            bus1.a = tt_in[i][1];
            bus1.b = tt_in[i][0];
            tick();
            chk($sformatf("tt%0d_diff", i), 32'(bus1.diff), 32'(tt_out[i][1]));
            chk($sformatf("tt%0d_bout", i), 32'(bus1.bout), 32'(tt_out[i][0]));
            chk($sformatf("tt%0d_out_valid", i), 32'(bus1.out_valid), 32'h1);
        end

        // Hold when in_valid is low
        bus1.in_valid = 1'b1; bus1.a = 1'b0; bus1.b = 1'b1;
        tick();
        bus1.in_valid = 1'b0; bus1.a = 1'b1; bus1.b = 1'b1;
        tick();
        chk("hold_diff", 32'(bus1.diff), 32'h1);
        chk("hold_bout", 32'(bus1.bout), 32'h1);
        chk("hold_out_valid", 32'(bus1.out_valid), 32'h0);

        // Asynchronous reset between edges
        bus1.in_valid = 1'b1; bus1.a = 1'b0; bus1.b = 1'b1;
        tick();
        chk("pre_rst_diff", 32'(bus1.diff), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_diff", 32'(bus1.diff), 32'h0);
        chk("async_rst_bout", 32'(bus1.bout), 32'h0);
        chk("async_rst_out_valid", 32'(bus1.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0;
        tick();
        chk("post_rst_diff", 32'(bus1.diff), 32'h1);
        chk("post_rst_bout", 32'(bus1.bout), 32'h0);
        chk("post_rst_out_valid", 32'(bus1.out_valid), 32'h1);
        bus1.in_valid = 1'b0;

        // Independent lanes
        bus4.in_valid = 1'b1; bus4.a = 4'b0101; bus4.b = 4'b0011;
        tick();
        chk("lane_diff", 32'(bus4.diff), 32'h6);
        chk("lane_bout", 32'(bus4.bout), 32'h2);
        chk("lane_out_valid", 32'(bus4.out_valid), 32'h1);
        bus4.a = 4'b1010; bus4.b = 4'b1100;
        tick();
        chk("lane2_diff", 32'(bus4.diff), 32'h6);
        chk("lane2_bout", 32'(bus4.bout), 32'h4);
        bus4.in_valid = 1'b0;
        tick();
        chk("lane_idle_out_valid", 32'(bus4.out_valid), 32'h0);
        chk("lane_idle_bout", 32'(bus4.bout), 32'h4);

`ifdef HALF_SUB_BORROW_COUNT_EN
        chk("cnt_start", 32'(borrow_cnt1), 32'h0);
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
            exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
            bus1.in_valid = 1'b1; bus1.a = 1'b0; bus1.b = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk($sformatf("cnt_sat%0d", i), 32'(borrow_cnt1), 32'(exp_cnt[i]));
            end
        end
        cnt_clr1 = 1'b1;
        tick();
        chk("cnt_clr_priority", 32'(borrow_cnt1), 32'h0);
        cnt_clr1 = 1'b0;
        tick();
        chk("cnt_after_clr", 32'(borrow_cnt1), 32'h1);
        bus1.a = 1'b1; bus1.b = 1'b1;
        tick();
        chk("cnt_no_borrow_11", 32'(borrow_cnt1), 32'h1);
        bus1.a = 1'b0; bus1.b = 1'b0;
        tick();
        chk("cnt_no_borrow_00", 32'(borrow_cnt1), 32'h1);
        bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b1;
        tick();
        chk("cnt_invalid_borrow", 32'(borrow_cnt1), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_subtractor_core.md
# half_subtractor_core

Registered single-bit (optionally lane-replicated) half subtractor. It computes the difference and borrow-out of `a - b` for each lane and captures the result one clock after a valid input. It is a leaf arithmetic primitive for ripple or staged subtractor chains in the datapath. It also offers an optional saturating borrow-event counter for debug.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent half-subtractor lanes.
- `CNT_W`, default 16: width of the borrow-event counter (only used with `HALF_SUB_BORROW_COUNT_EN`).

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; asserts immediately and deasserts synchronously to `clk` at system level.
- `in_valid`  input  1  qualifies `a`/`b` this cycle.
- `a`  input  WIDTH  minuend bits, one per lane.
- `b`  input  WIDTH  subtrahend bits, one per lane.
- `out_valid`  output  1  high for exactly the cycle after an accepted input.
- `diff`  output  WIDTH  registered difference per lane.
- `bout`  output  WIDTH  registered borrow-out per lane.
- `cnt_clr`  input  1  synchronous clear of the borrow counter (present only with the macro).
- `borrow_cnt`  output  CNT_W  saturating borrow-event count (present only with the macro).

## Operation
- Per lane i: `diff[i] = a[i] XOR b[i]`, `bout[i] = (NOT a[i]) AND b[i]`.
- Full truth table per lane (a,b → diff,bout): 0,0→0,0; 1,0→1,0; 0,1→1,1; 1,1→0,0.
- Lanes are fully independent; there is no borrow propagation between lanes.
- On a rising edge with `in_valid`=1: `diff`/`bout` load the computed values and `out_valid` is set to 1.
- On a rising edge with `in_valid`=0: `diff`/`bout` hold their previous values and `out_valid` is set to 0.
- There is no backpressure; every valid input is accepted.
- The block has no state machine; its only state is the output registers and the optional counter.

## Timing
- Latency: 1 cycle from an `in_valid` edge to the `out_valid`/`diff`/`bout` update.
- Throughput: one result per cycle. Back-to-back valids produce back-to-back `out_valid`.
- Reset (`rst_n`=0), effective immediately and independent of `clk`:
  - `diff`=0, `bout`=0, `out_valid`=0, `borrow_cnt`=0.
- Reset asserted mid-stream discards any in-flight result. The first valid input after deassertion appears one cycle later.
- Outputs are glitch-free registers; no combinational path exists from inputs to outputs.

## Configuration
- Macro: `HALF_SUB_BORROW_COUNT_EN`.
- When defined:
  - The `cnt_clr` and `borrow_cnt` ports exist.
  - `borrow_cnt` increments by 1 on each edge where `in_valid`=1 and any lane produces borrow (`|(~a & b)`).
  - The count saturates at 2^CNT_W-1.
  - `cnt_clr`=1 sets the count to 0 on the next edge, with priority over increment.
- When undefined: the ports and counter logic are absent, and the datapath behaves identically.

## Test plan
- Truth table, WIDTH=1, one valid vector per cycle: (a,b) = (0,0),(1,0),(0,1),(1,1) → one cycle later (diff,bout) = (0,0),(1,0),(1,1),(0,0), with `out_valid`=1 on each.
- Hold: apply a=0,b=1 valid, then `in_valid`=0 with a=1,b=1 → diff=1, bout=1 held and `out_valid`=0.
- Reset mid-stream:
  - Drive `rst_n`=0 between edges while diff=1 → diff, bout and `out_valid` go to 0 immediately without a clock.
  - After release, a=1,b=0 valid → diff=1, bout=0 after 1 cycle.
- Lanes, WIDTH=4: a=4'b0101, b=4'b0011 → diff=4'b0110, bout=4'b0010.
- Counter, macro on, CNT_W=2:
  - Five valid cycles with a=0,b=1 → `borrow_cnt` = 1,2,3,3,3 (saturates).
  - `cnt_clr` asserted together with another borrow → count becomes 0.
- Counter negative case: valid a=1,b=1 and a=0,b=0 → `borrow_cnt` unchanged.
